// File: rtl/tcdm_streamer_pkg.sv
// rtl/tcdm_streamer_pkg.sv - shared types for the TCDM read streamer
package tcdm_streamer_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] base;
    logic [DEF_ADDR_W-1:0] stride;
    logic [DEF_LEN_W-1:0]  len;
  } ctrl_t;

endpackage

// File: rtl/tcdm_stream_fifo.sv
// rtl/tcdm_stream_fifo.sv - response buffer, registered head, no push-to-pop bypass
module tcdm_stream_fifo
  import tcdm_streamer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tcdm_read_streamer.sv
// rtl/tcdm_read_streamer.sv - strided TCDM read initiator feeding a valid/ready stream
module tcdm_read_streamer
  import tcdm_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     stride_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_W-1:0]     tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_W/8-1:0]   tcdm_be_o,
  output logic [DATA_W-1:0]     tcdm_data_o,
  input  logic [DATA_W-1:0]     tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i,
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [DATA_W-1:0]     stream_data_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [ADDR_W-1:0] offset_q;
  logic [LEN_W-1:0]  issued_cnt, popped_cnt;
  logic [CNT_W-1:0]  outstanding_q, fifo_count;
  logic [CNT_W:0]    in_use;
  logic              flush, accept_start, grant, resp_push, pop;
  logic              last_grant, last_pop, fifo_full, fifo_empty;

  assign flush        = rst_i | clear_i;
  assign accept_start = (state_q == IDLE) & start_i;

  // Credit only shrinks on a grant, so an asserted request cannot lose
  // its credit before it is granted and req/add stay stable while stalled.
  assign in_use     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign tcdm_req_o = (state_q == RUN) && (in_use < (CNT_W+1)'(FIFO_DEPTH));
  assign grant      = tcdm_req_o & tcdm_gnt_i;
  assign resp_push  = tcdm_r_valid_i & (outstanding_q != '0);
  assign pop        = stream_valid_o & stream_ready_i;
  assign last_grant = grant && ((issued_cnt + LEN_W'(1)) == ctrl_q.len);
  assign last_pop   = pop && ((popped_cnt + LEN_W'(1)) == ctrl_q.len);

  assign tcdm_add_o     = ctrl_q.base + offset_q;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = ~fifo_empty;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      offset_q      <= '0;
      issued_cnt    <= '0;
      popped_cnt    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        ctrl_q     <= '{base: base_addr_i, stride: stride_i, len: len_i};
        offset_q   <= '0;
        issued_cnt <= '0;
        popped_cnt <= '0;
      end else begin
        if (grant) begin
          offset_q   <= offset_q + ctrl_q.stride;
          issued_cnt <= issued_cnt + LEN_W'(1);
        end
        if (pop) popped_cnt <= popped_cnt + LEN_W'(1);
      end
      if (grant && !resp_push)      outstanding_q <= outstanding_q + CNT_W'(1);
      else if (!grant && resp_push) outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i != '0) ? RUN : DONE;
      RUN:     if (last_grant) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  tcdm_stream_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .clear_i (flush),
    .push_i  (resp_push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop),
    .data_o  (stream_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_no_overflow : assert property (@(posedge clk_i) disable iff (flush)
    !(resp_push && fifo_full && !pop));

endmodule
